// File: rtl/frame_load_ctrl_pkg.sv
// Shared constants and state encoding for the frame loader.
// Protocol bytes, command codes, response codes and the FSM state type.
package frame_load_ctrl_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h55;
    localparam logic [7:0] CMD_WRITE = 8'h01;
    localparam logic [7:0] CMD_SWAP  = 8'h02;
    localparam logic [7:0] CMD_CLEAR = 8'h03;
    localparam logic [7:0] RESP_ACK  = 8'h06;
    localparam logic [7:0] RESP_NAK  = 8'h15;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR_H,
        ST_ADDR_L,
        ST_LEN,
        ST_PAYLOAD,
        ST_FILL,
        ST_CSUM,
        ST_CLEAR,
        ST_SWAP_WAIT,
        ST_RESP
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // States in which the host is mid-packet and the inter-byte timer runs.
    function automatic logic in_packet(input state_e s);
        return s inside {ST_CMD, ST_ADDR_H, ST_ADDR_L, ST_LEN,
                         ST_PAYLOAD, ST_FILL, ST_CSUM};
    endfunction

endpackage

// File: rtl/frame_load_ctrl_if.sv
// Byte-stream, RAM write port and response port of the frame loader.
// master = the loader, slave = UART/RAM side.
interface frame_load_ctrl_if #(
    parameter int unsigned ADDR_W = 16
);
    logic              rx_flag;
    logic [7:0]        rx_data;
    logic              tx_busy;
    logic              wr_en;
    logic [ADDR_W:0]   wr_addr;
    logic [7:0]        wr_data;
    logic              tx_req;
    logic [7:0]        tx_data;

    modport master (
        input  rx_flag, rx_data, tx_busy,
        output wr_en, wr_addr, wr_data, tx_req, tx_data
    );

    modport slave (
        output rx_flag, rx_data, tx_busy,
        input  wr_en, wr_addr, wr_data, tx_req, tx_data
    );
endinterface

// File: rtl/frame_load_timeout.sv
// Reloadable inter-byte timeout: down-counter with terminal-count expire.
// expire_o is asserted for the last counted cycle while enabled.
module frame_load_timeout #(
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic sclk_i,
    input  logic rst_i,
    input  logic reload_i,
    input  logic enable_i,
    output logic expire_o
);
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LOAD = CW'(TIMEOUT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (reload_i) begin
            cnt_d = LOAD;
        end else if (enable_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            cnt_q <= LOAD;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = enable_i && !reload_i && (cnt_q == '0);

endmodule

// File: rtl/frame_load_ctrl.sv
// Host-protocol loader: parses UART packets into writes on the hidden bank of a
// double-buffered frame RAM, clears banks, schedules bank swaps, sends ACK/NAK.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for sync 0x55, other bytes dropped
// ST_CMD       | waiting for command byte
// ST_ADDR_H    | WRITE: waiting for address high byte
// ST_ADDR_L    | WRITE: waiting for address low byte
// ST_LEN       | WRITE: waiting for length (0 = 256)
// ST_PAYLOAD   | WRITE: each byte written immediately to hidden bank
// ST_FILL      | CLEAR: waiting for fill byte
// ST_CSUM      | waiting for checksum byte
// ST_CLEAR     | sweeping fill value across the hidden bank
// ST_SWAP_WAIT | swap pending, waiting for frame_start
// ST_RESP      | holding ACK/NAK until transmitter is free
module frame_load_ctrl
    import frame_load_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W  = 16,
    parameter int unsigned TIMEOUT = 1_000_000
) (
    input  logic                sclk_i,
    input  logic                rst_i,
    input  logic                frame_start_i,
    frame_load_ctrl_if.master   bus,
    output logic                buf_sel_o,
    output logic                busy_o,
    output logic [7:0]          err_cnt_o
);

    state_e            state_q;
    logic [7:0]        cmd_q;
    logic [7:0]        ahi_q;
    logic [7:0]        chk_q;
    logic [7:0]        fill_q;
    logic [7:0]        resp_q;
    logic [7:0]        tx_data_q;
    logic [7:0]        err_cnt_q;
    logic [7:0]        wr_data_q;
    logic [8:0]        len_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic [ADDR_W:0]   wr_addr_q;
    logic              wr_en_q;
    logic              buf_sel_q;
    logic              swap_pend_q;

    logic              rx;
    logic [7:0]        rx_byte;
    logic              tmo_expire;
    logic              tx_fire;

    assign rx      = bus.rx_flag;
    assign rx_byte = bus.rx_data;

    frame_load_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .sclk_i   (sclk_i),
        .rst_i    (rst_i),
        .reload_i (rx),
        .enable_i (in_packet(state_q)),
        .expire_o (tmo_expire)
    );

    // tx_req must land in the very first cycle tx_busy is low, so it is the
    // registered RESP state gated by the live busy input.
    assign tx_fire = (state_q == ST_RESP) && !bus.tx_busy;

    always_ff @(posedge sclk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            cmd_q       <= '0;
            ahi_q       <= '0;
            chk_q       <= '0;
            fill_q      <= '0;
            resp_q      <= '0;
            tx_data_q   <= '0;
            err_cnt_q   <= '0;
            wr_data_q   <= '0;
            len_q       <= '0;
            addr_q      <= '0;
            clr_cnt_q   <= '0;
            wr_addr_q   <= '0;
            wr_en_q     <= 1'b0;
            buf_sel_q   <= 1'b0;
            swap_pend_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (tx_fire) begin
                tx_data_q <= resp_q;
            end

            if (tmo_expire) begin
                state_q   <= ST_IDLE;
                err_cnt_q <= sat_inc8(err_cnt_q);
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (rx && (rx_byte == SYNC_BYTE)) begin
                            state_q <= ST_CMD;
                        end
                    end
                    ST_CMD: begin
                        if (rx) begin
                            cmd_q <= rx_byte;
                            chk_q <= rx_byte;
                            case (rx_byte)
                                CMD_WRITE: state_q <= ST_ADDR_H;
                                CMD_SWAP:  state_q <= ST_CSUM;
                                CMD_CLEAR: state_q <= ST_FILL;
                                default: begin
                                    resp_q    <= RESP_NAK;
                                    err_cnt_q <= sat_inc8(err_cnt_q);
                                    state_q   <= ST_RESP;
                                end
                            endcase
                        end
                    end
                    ST_ADDR_H: begin
                        if (rx) begin
                            ahi_q   <= rx_byte;
                            chk_q   <= chk_q ^ rx_byte;
                            state_q <= ST_ADDR_L;
                        end
                    end
                    ST_ADDR_L: begin
                        if (rx) begin
                            addr_q  <= ADDR_W'({ahi_q, rx_byte});
                            chk_q   <= chk_q ^ rx_byte;
                            state_q <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (rx) begin
                            len_q   <= (rx_byte == 8'd0) ? 9'd256 : {1'b0, rx_byte};
                            chk_q   <= chk_q ^ rx_byte;
                            state_q <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        if (rx) begin
                            wr_en_q   <= 1'b1;
                            wr_addr_q <= {~buf_sel_q, addr_q};
                            wr_data_q <= rx_byte;
                            addr_q    <= addr_q + ADDR_W'(1);
                            chk_q     <= chk_q ^ rx_byte;
                            len_q     <= len_q - 9'd1;
                            if (len_q == 9'd1) begin
                                state_q <= ST_CSUM;
                            end
                        end
                    end
                    ST_FILL: begin
                        if (rx) begin
                            fill_q  <= rx_byte;
                            chk_q   <= chk_q ^ rx_byte;
                            state_q <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (rx) begin
                            if (chk_q != rx_byte) begin
                                resp_q  <= RESP_NAK;
                                state_q <= ST_RESP;
                            end else begin
                                case (cmd_q)
                                    CMD_CLEAR: begin
                                        // offset 0 issued here so the sweep starts next cycle
                                        wr_en_q   <= 1'b1;
                                        wr_addr_q <= {~buf_sel_q, {ADDR_W{1'b0}}};
                                        wr_data_q <= fill_q;
                                        clr_cnt_q <= ADDR_W'(1);
                                        state_q   <= ST_CLEAR;
                                    end
                                    CMD_SWAP: begin
                                        swap_pend_q <= 1'b1;
                                        state_q     <= ST_SWAP_WAIT;
                                    end
                                    default: begin
                                        resp_q  <= RESP_ACK;
                                        state_q <= ST_RESP;
                                    end
                                endcase
                            end
                        end
                    end
                    ST_CLEAR: begin
                        if (rx) begin
                            err_cnt_q <= sat_inc8(err_cnt_q);
                        end
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= {~buf_sel_q, clr_cnt_q};
                        wr_data_q <= fill_q;
                        clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                        if (clr_cnt_q == {ADDR_W{1'b1}}) begin
                            resp_q  <= RESP_ACK;
                            state_q <= ST_RESP;
                        end
                    end
                    ST_SWAP_WAIT: begin
                        if (rx) begin
                            err_cnt_q <= sat_inc8(err_cnt_q);
                        end
                        if (frame_start_i && swap_pend_q) begin
                            buf_sel_q   <= ~buf_sel_q;
                            swap_pend_q <= 1'b0;
                            resp_q      <= RESP_ACK;
                            state_q     <= ST_RESP;
                        end
                    end
                    ST_RESP: begin
                        if (rx) begin
                            err_cnt_q <= sat_inc8(err_cnt_q);
                        end
                        if (!bus.tx_busy) begin
                            state_q <= ST_IDLE;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;
    assign bus.tx_req  = tx_fire;
    assign bus.tx_data = tx_fire ? resp_q : tx_data_q;

    assign buf_sel_o = buf_sel_q;
    assign busy_o    = (state_q != ST_IDLE);
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_frame_load_ctrl.sv
// Directed bench for frame_load_ctrl: a 16-bit-address instance for WRITE/SWAP/
// timeout traffic and a 4-bit-address instance for CLEAR sweeps and reset.
module tb_frame_load_ctrl;

    localparam int TMO = 40;

    logic       sclk = 1'b0;
    always #5 sclk = ~sclk;

    logic       rst16, rst4, rx_flag, tx_busy, frame_start, sel4;
    logic [7:0] rx_data;
    logic       buf_sel16, busy16, buf_sel4, busy4;
    logic [7:0] err16, err4;

    int cyc = 0;
    int n_cmp = 0;
    int n_fail = 0;

    frame_load_ctrl_if #(.ADDR_W(16)) if16 ();
    frame_load_ctrl_if #(.ADDR_W(4))  if4 ();

    assign if16.rx_flag = rx_flag & ~sel4;
    assign if16.rx_data = rx_data;
    assign if16.tx_busy = tx_busy;
    assign if4.rx_flag  = rx_flag & sel4;
    assign if4.rx_data  = rx_data;
    assign if4.tx_busy  = tx_busy;

    frame_load_ctrl #(.ADDR_W(16), .TIMEOUT(TMO)) dut16 (
        .sclk_i        (sclk),
        .rst_i         (rst16),
        .frame_start_i (frame_start),
        .bus           (if16),
        .buf_sel_o     (buf_sel16),
        .busy_o        (busy16),
        .err_cnt_o     (err16)
    );

    frame_load_ctrl #(.ADDR_W(4), .TIMEOUT(TMO)) dut4 (
        .sclk_i        (sclk),
        .rst_i         (rst4),
        .frame_start_i (frame_start),
        .bus           (if4),
        .buf_sel_o     (buf_sel4),
        .busy_o        (busy4),
        .err_cnt_o     (err4)
    );

    typedef struct {
        logic [16:0] addr;
        logic [7:0]  data;
        int          cyc;
    } wr_t;

    wr_t        wq16[$];
    wr_t        wq4[$];
    logic [7:0] tq16[$];
    logic [7:0] tq4[$];

    always @(posedge sclk) cyc <= cyc + 1;

    always @(negedge sclk) begin
        if (if16.wr_en === 1'b1) wq16.push_back('{addr: if16.wr_addr, data: if16.wr_data, cyc: cyc});
        if (if4.wr_en === 1'b1)  wq4.push_back('{addr: {12'd0, if4.wr_addr}, data: if4.wr_data, cyc: cyc});
        if (if16.tx_req === 1'b1) tq16.push_back(if16.tx_data);
        if (if4.tx_req === 1'b1)  tq4.push_back(if4.tx_data);
    end

    task automatic send(input logic [7:0] b, output int c);
        @(posedge sclk); #1;
        rx_flag = 1'b1;
        rx_data = b;
        @(negedge sclk);
        c = cyc;
        @(posedge sclk); #1;
        rx_flag = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input int n);
        int c;
        send(b0, c);
        if (n > 1) send(b1, c);
        if (n > 2) send(b2, c);
    endtask

    task automatic wait_tx(input bit d4, input int n0, input int lim);
        for (int i = 0; i < lim; i++) begin
            if ((d4 ? tq4.size() : tq16.size()) > n0) break;
            @(negedge sclk);
        end
    endtask

    task automatic pulse_fs();
        @(posedge sclk); #1;
        frame_start = 1'b1;
        @(posedge sclk); #1;
        frame_start = 1'b0;
    endtask

    task automatic test_reset();
        rst16 = 1'b1; rst4 = 1'b1;
        rx_flag = 1'b0; rx_data = 8'h00; tx_busy = 1'b0; frame_start = 1'b0; sel4 = 1'b0;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        n_cmp++; if (if16.wr_en !== 1'b0)     begin n_fail++; $display("FAIL reset_wr_en got=%b exp=0", if16.wr_en); end
        n_cmp++; if (if16.wr_addr !== 17'd0)  begin n_fail++; $display("FAIL reset_wr_addr got=%h exp=0", if16.wr_addr); end
        n_cmp++; if (if16.wr_data !== 8'd0)   begin n_fail++; $display("FAIL reset_wr_data got=%h exp=0", if16.wr_data); end
        n_cmp++; if (buf_sel16 !== 1'b0)      begin n_fail++; $display("FAIL reset_buf_sel got=%b exp=0", buf_sel16); end
        n_cmp++; if (if16.tx_req !== 1'b0)    begin n_fail++; $display("FAIL reset_tx_req got=%b exp=0", if16.tx_req); end
        n_cmp++; if (if16.tx_data !== 8'd0)   begin n_fail++; $display("FAIL reset_tx_data got=%h exp=0", if16.tx_data); end
        n_cmp++; if (busy16 !== 1'b0)         begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy16); end
        n_cmp++; if (err16 !== 8'd0)          begin n_fail++; $display("FAIL reset_err_cnt got=%h exp=0", err16); end
        n_cmp++; if (busy4 !== 1'b0 || err4 !== 8'd0) begin n_fail++; $display("FAIL reset_dut4 got busy=%b err=%h exp 0/0", busy4, err4); end
        @(posedge sclk); #1;
        rst16 = 1'b0; rst4 = 1'b0;
    endtask

    task automatic test_write();
        int c[3];
        int cx;
        int n0w, n0t;
        logic [7:0] pay[3];
        pay[0] = 8'hAA; pay[1] = 8'hBB; pay[2] = 8'hCC;
        n0w = wq16.size(); n0t = tq16.size();
        tx_busy = 1'b1;
        send_seq(8'h55, 8'h01, 8'h12, 3);
        send_seq(8'h34, 8'h03, 8'h00, 2);
        for (int i = 0; i < 3; i++) send(pay[i], c[i]);
        send(8'hF9, cx);
        repeat (3) @(negedge sclk);
        n_cmp++; if (tq16.size() != n0t) begin n_fail++; $display("FAIL write_tx_held got=%0d exp=%0d", tq16.size(), n0t); end
        n_cmp++; if (busy16 !== 1'b1) begin n_fail++; $display("FAIL write_busy_in_resp got=%b exp=1", busy16); end
        tx_busy = 1'b0;
        wait_tx(1'b0, n0t, 20);
        n_cmp++; if (tq16.size() != n0t + 1) begin n_fail++; $display("FAIL write_ack_count got=%0d exp=%0d", tq16.size(), n0t + 1); end
        else begin
            n_cmp++; if (tq16[n0t] !== 8'h06) begin n_fail++; $display("FAIL write_ack_byte got=%h exp=06", tq16[n0t]); end
        end
        n_cmp++; if (wq16.size() != n0w + 3) begin n_fail++; $display("FAIL write_count got=%0d exp=%0d", wq16.size(), n0w + 3); end
        else begin
            for (int i = 0; i < 3; i++) begin
                n_cmp++;
                if (wq16[n0w+i].addr !== 17'h11234 + 17'(i) || wq16[n0w+i].data !== pay[i] || wq16[n0w+i].cyc != c[i] + 1)
                begin n_fail++; $display("FAIL write_beat%0d got addr=%h data=%h cyc=%0d exp addr=%h data=%h cyc=%0d", i, wq16[n0w+i].addr, wq16[n0w+i].data, wq16[n0w+i].cyc, 17'h11234 + 17'(i), pay[i], c[i] + 1); end
            end
        end
        repeat (2) @(negedge sclk);
        n_cmp++; if (busy16 !== 1'b0 || if16.tx_data !== 8'h06 || if16.tx_req !== 1'b0)
        begin n_fail++; $display("FAIL write_after_resp got busy=%b tx_data=%h tx_req=%b exp 0/06/0", busy16, if16.tx_data, if16.tx_req); end
    endtask

    task automatic test_write_wrap();
        int n0w, n0t;
        n0w = wq16.size(); n0t = tq16.size();
        send_seq(8'h55, 8'h01, 8'hFF, 3);
        send_seq(8'hFF, 8'h02, 8'h11, 3);
        send_seq(8'h22, 8'h31, 8'h00, 2);
        wait_tx(1'b0, n0t, 20);
        n_cmp++; if (tq16.size() != n0t + 1 || tq16[n0t] !== 8'h15) begin n_fail++; $display("FAIL wrap_nak got n=%0d byte=%h exp n=%0d byte=15", tq16.size(), tq16[n0t], n0t + 1); end
        n_cmp++; if (wq16.size() != n0w + 2) begin n_fail++; $display("FAIL wrap_count got=%0d exp=%0d", wq16.size(), n0w + 2); end
        else begin
            n_cmp++; if (wq16[n0w].addr !== 17'h1FFFF || wq16[n0w].data !== 8'h11) begin n_fail++; $display("FAIL wrap_beat0 got=%h/%h exp=1ffff/11", wq16[n0w].addr, wq16[n0w].data); end
            n_cmp++; if (wq16[n0w+1].addr !== 17'h10000 || wq16[n0w+1].data !== 8'h22) begin n_fail++; $display("FAIL wrap_beat1 got=%h/%h exp=10000/22", wq16[n0w+1].addr, wq16[n0w+1].data); end
        end
        n_cmp++; if (err16 !== 8'd0) begin n_fail++; $display("FAIL wrap_err_cnt got=%0d exp=0", err16); end
    endtask

    task automatic test_swap();
        int n0t, n0w;
        n0t = tq16.size();
        send_seq(8'h55, 8'h02, 8'h00, 2);
        @(posedge sclk); #1;
        rx_flag = 1'b1; rx_data = 8'h02; frame_start = 1'b1;
        @(posedge sclk); #1;
        rx_flag = 1'b0; frame_start = 1'b0;
        repeat (5) @(negedge sclk);
        n_cmp++; if (buf_sel16 !== 1'b0 || busy16 !== 1'b1 || tq16.size() != n0t)
        begin n_fail++; $display("FAIL swap_pending got buf_sel=%b busy=%b ntx=%0d exp 0/1/%0d", buf_sel16, busy16, tq16.size(), n0t); end
        @(posedge sclk); #1;
        frame_start = 1'b1;
        @(negedge sclk);
        n_cmp++; if (buf_sel16 !== 1'b0) begin n_fail++; $display("FAIL swap_same_cycle got=%b exp=0", buf_sel16); end
        @(posedge sclk); #1;
        frame_start = 1'b0;
        @(negedge sclk);
        n_cmp++; if (buf_sel16 !== 1'b1) begin n_fail++; $display("FAIL swap_toggle got=%b exp=1", buf_sel16); end
        wait_tx(1'b0, n0t, 10);
        n_cmp++; if (tq16.size() != n0t + 1 || tq16[n0t] !== 8'h06) begin n_fail++; $display("FAIL swap_ack got n=%0d byte=%h exp n=%0d byte=06", tq16.size(), tq16[n0t], n0t + 1); end
        repeat (2) @(negedge sclk);
        n0w = wq16.size(); n0t = tq16.size();
        send_seq(8'h55, 8'h01, 8'h00, 3);
        send_seq(8'h05, 8'h01, 8'hEE, 3);
        send_seq(8'hEB, 8'h00, 8'h00, 1);
        wait_tx(1'b0, n0t, 20);
        n_cmp++; if (wq16.size() != n0w + 1 || wq16[n0w].addr !== 17'h00005 || wq16[n0w].data !== 8'hEE)
        begin n_fail++; $display("FAIL post_swap_write got n=%0d addr=%h data=%h exp n=%0d addr=00005 data=ee", wq16.size(), wq16[n0w].addr, wq16[n0w].data, n0w + 1); end
        n_cmp++; if (tq16.size() != n0t + 1 || tq16[n0t] !== 8'h06) begin n_fail++; $display("FAIL post_swap_ack got n=%0d byte=%h exp 06", tq16.size(), tq16[n0t]); end
    endtask

    task automatic test_timeout();
        int n0t;
        repeat (3) @(negedge sclk);
        n0t = tq16.size();
        send_seq(8'h55, 8'h01, 8'h00, 3);
        repeat (TMO - 4) @(negedge sclk);
        n_cmp++; if (busy16 !== 1'b1) begin n_fail++; $display("FAIL timeout_early got busy=%b exp=1", busy16); end
        repeat (8) @(negedge sclk);
        n_cmp++; if (busy16 !== 1'b0) begin n_fail++; $display("FAIL timeout_idle got busy=%b exp=0", busy16); end
        n_cmp++; if (err16 !== 8'd1) begin n_fail++; $display("FAIL timeout_err_cnt got=%0d exp=1", err16); end
        n_cmp++; if (tq16.size() != n0t) begin n_fail++; $display("FAIL timeout_no_tx got=%0d exp=%0d", tq16.size(), n0t); end
    endtask

    task automatic test_unknown_cmd();
        int n0t;
        n0t = tq16.size();
        tx_busy = 1'b1;
        send_seq(8'h55, 8'h07, 8'h99, 3);
        repeat (2) @(negedge sclk);
        n_cmp++; if (err16 !== 8'd3 || tq16.size() != n0t) begin n_fail++; $display("FAIL unknown_err got err=%0d ntx=%0d exp 3/%0d", err16, tq16.size(), n0t); end
        tx_busy = 1'b0;
        wait_tx(1'b0, n0t, 10);
        n_cmp++; if (tq16.size() != n0t + 1 || tq16[n0t] !== 8'h15) begin n_fail++; $display("FAIL unknown_nak got n=%0d byte=%h exp 15", tq16.size(), tq16[n0t]); end
    endtask

    task automatic test_clear();
        int n0t, n0w, c, cd;
        sel4 = 1'b1;
        n0t = tq4.size();
        send_seq(8'h55, 8'h02, 8'h02, 3);
        pulse_fs();
        wait_tx(1'b1, n0t, 10);
        n_cmp++; if (buf_sel4 !== 1'b1 || tq4.size() != n0t + 1) begin n_fail++; $display("FAIL clear_pre_swap got buf_sel=%b ntx=%0d exp 1/%0d", buf_sel4, tq4.size(), n0t + 1); end
        repeat (2) @(negedge sclk);
        n0t = tq4.size(); n0w = wq4.size();
        send_seq(8'h55, 8'h03, 8'h5A, 3);
        send(8'h59, c);
        send(8'h77, cd);
        wait_tx(1'b1, n0t, 40);
        n_cmp++; if (wq4.size() != n0w + 16) begin n_fail++; $display("FAIL clear_count got=%0d exp=%0d", wq4.size(), n0w + 16); end
        else begin
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (wq4[n0w+i].addr !== 17'(i) || wq4[n0w+i].data !== 8'h5A || wq4[n0w+i].cyc != c + 1 + i)
                begin n_fail++; $display("FAIL clear_beat%0d got addr=%h data=%h cyc=%0d exp addr=%h data=5a cyc=%0d", i, wq4[n0w+i].addr, wq4[n0w+i].data, wq4[n0w+i].cyc, 17'(i), c + 1 + i); end
            end
        end
        n_cmp++; if (err4 !== 8'd1) begin n_fail++; $display("FAIL clear_midsweep_err got=%0d exp=1", err4); end
        n_cmp++; if (tq4.size() != n0t + 1 || tq4[n0t] !== 8'h06) begin n_fail++; $display("FAIL clear_ack got n=%0d byte=%h exp 06", tq4.size(), tq4[n0t]); end
    endtask

    task automatic test_reset_mid_clear();
        int n0t, n1w, c;
        repeat (2) @(negedge sclk);
        n0t = tq4.size();
        send_seq(8'h55, 8'h03, 8'h3C, 3);
        send(8'h3F, c);
        repeat (3) @(posedge sclk);
        #1 rst4 = 1'b1;
        @(posedge sclk); #1;
        rst4 = 1'b0;
        @(negedge sclk);
        n_cmp++; if (if4.wr_en !== 1'b0)  begin n_fail++; $display("FAIL rst_clear_wr_en got=%b exp=0", if4.wr_en); end
        n_cmp++; if (buf_sel4 !== 1'b0)   begin n_fail++; $display("FAIL rst_clear_buf_sel got=%b exp=0", buf_sel4); end
        n_cmp++; if (busy4 !== 1'b0)      begin n_fail++; $display("FAIL rst_clear_busy got=%b exp=0", busy4); end
        n_cmp++; if (err4 !== 8'd0)       begin n_fail++; $display("FAIL rst_clear_err_cnt got=%0d exp=0", err4); end
        n1w = wq4.size();
        repeat (30) @(negedge sclk);
        n_cmp++; if (wq4.size() != n1w || tq4.size() != n0t)
        begin n_fail++; $display("FAIL rst_clear_quiet got nwr=%0d ntx=%0d exp %0d/%0d", wq4.size(), tq4.size(), n1w, n0t); end
        sel4 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_wrap();
        test_swap();
        test_timeout();
        test_unknown_cmd();
        test_clear();
        test_reset_mid_clear();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_load_ctrl.md
# frame_load_ctrl

Command-driven loader that sequences UART-received bytes into a double-buffered frame RAM. Sits between the UART receiver (byte + strobe) and the RAM write port. Parses a framed host protocol, issues RAM writes into the bank not being displayed, and swaps banks on the next frame boundary. It returns ACK/NAK bytes through the UART transmitter.

## Interface
Parameters:
- ADDR_W, 16, address width of one bank; frame RAM holds 2 banks of 2^ADDR_W bytes
- TIMEOUT, 1_000_000, inter-byte timeout in sclk cycles

Ports:
- sclk  in  1  system clock; the only clock
- rst  in  1  synchronous, active-high reset
- rx_flag  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- frame_start  in  1  one-cycle pulse at start of vertical blank
- tx_busy  in  1  transmitter busy; tx_req ignored while high
- wr_en  out  1  RAM write enable
- wr_addr  out  ADDR_W+1  {bank, offset}; bank = ~buf_sel
- wr_data  out  8  RAM write data
- buf_sel  out  1  bank currently displayed (read side)
- tx_req  out  1  one-cycle send strobe
- tx_data  out  8  response byte
- busy  out  1  high in any state other than IDLE
- err_cnt  out  8  saturating protocol-error count

## Operation
- Packet: 0x55 sync, cmd, fields, chk. chk = XOR of every byte from cmd through the last field/payload byte.
- WRITE 0x01: addr_hi, addr_lo, len (0 means 256), len payload bytes, chk. Each payload byte is written at once to offset addr+i. The offset wraps modulo 2^ADDR_W.
- CLEAR 0x03: fill, chk. If chk is good, writes fill to all 2^ADDR_W offsets of the write bank at one per cycle, then sends ACK.
- SWAP 0x02: chk. If chk is good, sets swap_pend. At the next frame_start, buf_sel toggles, swap_pend clears, and ACK is sent.
- Responses: ACK 0x06 for a good chk. NAK 0x15 for a bad chk or an unknown cmd. A bad chk after WRITE does not undo payload writes already done.
- FSM states: IDLE, CMD, ADDR_H, ADDR_L, LEN, PAYLOAD, FILL, CSUM, CLEAR, SWAP_WAIT, RESP.
- IDLE: bytes other than 0x55 are dropped silently.
- CMD: an unknown cmd sends NAK, increments err_cnt, and goes to RESP.
- Timeout: a counter reloads on every rx_flag in any state CMD..CSUM. On expiry: go to IDLE, increment err_cnt, send no response.
- rx_flag in CLEAR, SWAP_WAIT or RESP: the byte is dropped and err_cnt increments.
- err_cnt saturates at 255.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, buf_sel=0, tx_req=0, tx_data=0, busy=0, err_cnt=0, swap_pend=0. State is IDLE.
- Reset mid-operation abandons the packet, CLEAR sweep and pending swap. No response is sent.
- Payload write: wr_en is high for exactly the cycle after the payload byte's rx_flag. wr_addr and wr_data are registered with it.
- CLEAR: wr_en is high for 2^ADDR_W consecutive cycles, starting the cycle after chk is accepted. Offsets run 0..2^ADDR_W-1.
- frame_start in the same cycle SWAP's chk is accepted does not swap. The swap waits for the next frame_start.
- buf_sel toggles in the cycle after the qualifying frame_start. The first write after the swap targets the new ~buf_sel.
- RESP: tx_req pulses for one cycle, in the first cycle with tx_busy=0. tx_data is stable from that cycle until the next tx_req. FSM returns to IDLE the cycle after tx_req.

## Structure
- Shared package: sync byte 0x55, cmd codes 0x01/0x02/0x03, ACK 0x06, NAK 0x15, and the state encoding.
- One natural sub-module: frame_load_timeout, the reloadable inter-byte timeout counter (inputs: reload, enable; output: expire pulse).
- Remaining logic lives in one FSM with its address/length/checksum registers.

## Test plan
- WRITE: 55 01 12 34 03 AA BB CC chk=01^12^34^03^AA^BB^CC → writes AA/BB/CC to {1,0x1234}..{1,0x1236}; one ACK 06.
- WRITE with addr FFFF, len 2 and a corrupted chk → writes at {1,FFFF} then {1,0000}; NAK 15; err_cnt unchanged.
- SWAP: 55 02 02 → no toggle until frame_start; buf_sel goes 0→1 the cycle after the pulse; ACK sent. A frame_start in the chk-accept cycle is ignored.
- CLEAR with ADDR_W=4: 55 03 5A chk → 16 consecutive wr_en cycles, offsets 0..15, data 5A, bank ~buf_sel; ACK. A byte sent mid-sweep increments err_cnt.
- 55 01 00, then silence for TIMEOUT cycles → IDLE; err_cnt=1; tx_req never asserted.
- Assert rst during a CLEAR sweep → next cycle wr_en=0, buf_sel=0, busy=0, err_cnt=0.
